// File: rtl/pc_sequencer.sv
// Fetch-side controller: owns the PC, runs the imem request/ack handshake, hands instructions
// to decode over valid/ready, and selects the next PC from the resolved control-flow outcome.
module pc_sequencer #(
   parameter int unsigned   N        = 32,
   parameter logic [N-1:0]  RESET_PC = '0,
   parameter logic [N-1:0]  TRAP_VEC = N'('h100)
) (
   input  logic          clk,
   input  logic          rst,
   output logic          imem_req,
   output logic [N-1:0]  imem_addr,
   input  logic          imem_ack,
   input  logic [31:0]   imem_rdata,
   output logic          inst_valid,
   input  logic          inst_ready,
   output logic [31:0]   inst,
   output logic [N-1:0]  inst_pc,
   input  logic          redirect_valid,
   input  logic [1:0]    redirect_kind,
   input  logic          branch_taken,
   input  logic [N-1:0]  target_branch,
   input  logic [N-1:0]  target_jalr,
   input  logic          halt,
   input  logic          resume,
   output logic [N-1:0]  pc,
   output logic          pc_sel1,
   output logic [1:0]    pc_sel2,
   output logic [31:0]   instret
);

   typedef enum logic [1:0] {StIdle, StFetch, StIssue, StHalted} state_t;

   localparam logic [1:0] KindBranch = 2'b00;
   localparam logic [1:0] KindJal    = 2'b01;
   localparam logic [1:0] KindJalr   = 2'b10;
   localparam logic [1:0] KindTrap   = 2'b11;

   state_t        state_q, state_d;
   logic [N-1:0]  pc_q, pc_d;
   logic [N-1:0]  inst_pc_q, inst_pc_d;
   logic [31:0]   inst_q, inst_d;
   logic [31:0]   instret_q, instret_d;
   logic [2:0]    sel;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= StIdle;
         pc_q      <= RESET_PC;
         inst_pc_q <= '0;
         inst_q    <= '0;
         instret_q <= '0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         inst_pc_q <= inst_pc_d;
         inst_q    <= inst_d;
         instret_q <= instret_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      inst_pc_d = inst_pc_q;
      inst_d    = inst_q;
      instret_d = instret_q;
      sel       = 3'b000;
      unique case (state_q)
         StIdle: state_d = StFetch;
         StFetch: begin
            if (imem_ack) begin
               inst_d    = imem_rdata;
               inst_pc_d = pc_q;
               state_d   = StIssue;
            end
         end
         StIssue: begin
            if (inst_ready) begin
               instret_d = instret_q + 32'd1;
               if (redirect_valid && redirect_kind == KindTrap) begin
                  pc_d = TRAP_VEC;
                  sel  = 3'b001;
               end else if (redirect_valid && redirect_kind == KindJalr) begin
                  pc_d = {target_jalr[N-1:1], 1'b0};
                  sel  = 3'b110;
               end else if (redirect_valid && (redirect_kind == KindJal ||
                            (redirect_kind == KindBranch && branch_taken))) begin
                  pc_d = target_branch;
                  sel  = 3'b100;
               end else begin
                  pc_d = inst_pc_q + N'(4);
               end
               // Halt wins over resume on the accept cycle; resume is only seen in StHalted.
               state_d = halt ? StHalted : StFetch;
            end
         end
         StHalted: begin
            if (resume) state_d = StFetch;
         end
         default: state_d = StIdle;
      endcase
   end

   assign imem_req   = (state_q == StFetch);
   assign imem_addr  = pc_q;
   assign inst_valid = (state_q == StIssue);
   assign inst       = inst_q;
   assign inst_pc    = inst_pc_q;
   assign pc         = pc_q;
   assign instret    = instret_q;
   assign pc_sel1    = sel[0];
   assign pc_sel2    = sel[2:1];

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed plus randomized bench for pc_sequencer; a small behavioural model tracks the
// expected PC and retired count from the control-flow rules.
module tb_pc_sequencer;

   logic        clk = 1'b0;
   logic        rst;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic        inst_valid;
   logic        inst_ready;
   logic [31:0] inst;
   logic [31:0] inst_pc;
   logic        redirect_valid;
   logic [1:0]  redirect_kind;
   logic        branch_taken;
   logic [31:0] target_branch;
   logic [31:0] target_jalr;
   logic        halt;
   logic        resume;
   logic [31:0] pc;
   logic        pc_sel1;
   logic [1:0]  pc_sel2;
   logic [31:0] instret;

   int          checks = 0;
   int          errors = 0;
   logic [31:0] m_pc;
   logic [31:0] m_instret;

   pc_sequencer dut (
      .clk            (clk),
      .rst            (rst),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_ack       (imem_ack),
      .imem_rdata     (imem_rdata),
      .inst_valid     (inst_valid),
      .inst_ready     (inst_ready),
      .inst           (inst),
      .inst_pc        (inst_pc),
      .redirect_valid (redirect_valid),
      .redirect_kind  (redirect_kind),
      .branch_taken   (branch_taken),
      .target_branch  (target_branch),
      .target_jalr    (target_jalr),
      .halt           (halt),
      .resume         (resume),
      .pc             (pc),
      .pc_sel1        (pc_sel1),
      .pc_sel2        (pc_sel2),
      .instret        (instret)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Reference rules for the next PC and the mux select on an accepted instruction.
   function automatic void ref_next(input logic [31:0] cur, input logic rv, input logic [1:0] kind,
                                    input logic bt, input logic [31:0] tbr, input logic [31:0] tj,
                                    output logic [31:0] npc, output logic [2:0] esel);
      if (rv && kind == 2'd3) begin
         npc = 32'h100;          esel = 3'b001;
      end else if (rv && kind == 2'd2) begin
         npc = tj - (tj % 2);    esel = 3'b110;
      end else if (rv && (kind == 2'd1 || (kind == 2'd0 && bt))) begin
         npc = tbr;              esel = 3'b100;
      end else begin
         npc = cur + 32'd4;      esel = 3'b000;
      end
   endfunction

   task automatic wait_req();
      int n = 0;
      while (imem_req !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("req_seen", imem_req, 1);
   endtask

   task automatic fetch(input int lat, input logic [31:0] data);
      wait_req();
      for (int i = 1; i < lat; i++) begin
         check("fetch_addr_hold", imem_addr, m_pc);
         check("fetch_req_hold", imem_req, 1);
         @(negedge clk);
      end
      check("fetch_addr", imem_addr, m_pc);
      imem_ack   = 1'b1;
      imem_rdata = data;
      @(negedge clk);
      imem_ack   = 1'b0;
      imem_rdata = $urandom;
      check("inst_valid", inst_valid, 1);
      check("inst", inst, data);
      check("inst_pc", inst_pc, m_pc);
   endtask

   task automatic issue(input int stall, input logic [31:0] data, input logic rv,
                        input logic [1:0] kind, input logic bt, input logic [31:0] tbr,
                        input logic [31:0] tj, input logic h, input logic res);
      logic [31:0] npc;
      logic [2:0]  esel;
      for (int i = 0; i < stall; i++) begin
         // Noise on the sampled-at-accept inputs must not matter while decode stalls.
         inst_ready     = 1'b0;
         redirect_valid = 1'($urandom);
         redirect_kind  = 2'($urandom);
         branch_taken   = 1'($urandom);
         halt           = 1'($urandom);
         resume         = 1'($urandom);
         #1;
         check("sel_stall", {29'd0, pc_sel2, pc_sel1}, 0);
         @(negedge clk);
         check("stall_inst", inst, data);
         check("stall_inst_pc", inst_pc, m_pc);
         check("stall_valid", inst_valid, 1);
         check("stall_instret", instret, m_instret);
      end
      inst_ready     = 1'b1;
      redirect_valid = rv;
      redirect_kind  = kind;
      branch_taken   = bt;
      target_branch  = tbr;
      target_jalr    = tj;
      halt           = h;
      resume         = res;
      ref_next(m_pc, rv, kind, bt, tbr, tj, npc, esel);
      #1;
      check("sel_accept", {29'd0, pc_sel2, pc_sel1}, {29'd0, esel});
      @(negedge clk);
      inst_ready     = 1'b0;
      redirect_valid = 1'b0;
      halt           = 1'b0;
      resume         = 1'b0;
      m_instret      = m_instret + 1;
      m_pc           = npc;
      check("instret", instret, m_instret);
      check("next_pc", pc, m_pc);
      check("valid_drop", inst_valid, 0);
      check("sel_idle", {29'd0, pc_sel2, pc_sel1}, 0);
   endtask

   task automatic halted_wait(input int cycles);
      for (int i = 0; i < cycles; i++) begin
         check("halt_no_req", imem_req, 0);
         check("halt_no_valid", inst_valid, 0);
         @(negedge clk);
      end
      resume = 1'b1;
      @(negedge clk);
      resume = 1'b0;
   endtask

   task automatic check_reset_values();
      check("rst_req", imem_req, 0);
      check("rst_addr", imem_addr, 0);
      check("rst_pc", pc, 0);
      check("rst_valid", inst_valid, 0);
      check("rst_inst", inst, 0);
      check("rst_inst_pc", inst_pc, 0);
      check("rst_instret", instret, 0);
      check("rst_sel", {29'd0, pc_sel2, pc_sel1}, 0);
   endtask

   initial begin
      logic [31:0] d;
      logic        h;
      rst = 1'b1;
      imem_ack = 1'b0; imem_rdata = '0; inst_ready = 1'b0;
      redirect_valid = 1'b0; redirect_kind = '0; branch_taken = 1'b0;
      target_branch = '0; target_jalr = '0; halt = 1'b0; resume = 1'b0;
      m_pc = 32'h0;
      m_instret = 32'h0;
      #1;
      check_reset_values();
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;

      // Sequential flow 0x0, 0x4, 0x8, then on to 0x10.
      fetch(2, 32'h0000_0013); issue(0, 32'h0000_0013, 0, 0, 0, 0, 0, 0, 0);
      fetch(1, 32'h0010_0093); issue(0, 32'h0010_0093, 0, 0, 0, 0, 0, 0, 0);
      fetch(2, 32'h0020_0113); issue(0, 32'h0020_0113, 0, 0, 0, 0, 0, 0, 0);
      check("instret_three", instret, 3);
      fetch(1, 32'h1111_1111); issue(0, 32'h1111_1111, 0, 0, 0, 0, 0, 0, 0);
      // Taken branch at 0x10 -> 0x40, jal back to 0x10, not-taken branch -> 0x14.
      fetch(1, 32'h2222_2222); issue(0, 32'h2222_2222, 1, 2'd0, 1, 32'h40, 32'h0, 0, 0);
      fetch(1, 32'h3333_3333); issue(0, 32'h3333_3333, 1, 2'd1, 0, 32'h10, 32'h0, 0, 0);
      fetch(1, 32'h4444_4444); issue(0, 32'h4444_4444, 1, 2'd0, 0, 32'h40, 32'h0, 0, 0);
      // jalr clears bit 0; trap goes to the vector.
      fetch(1, 32'h5555_5555); issue(0, 32'h5555_5555, 1, 2'd2, 1, 32'h40, 32'h123, 0, 0);
      fetch(1, 32'h6666_6666); issue(0, 32'h6666_6666, 1, 2'd3, 1, 32'h40, 32'h123, 0, 0);
      // Slow memory and stalling decode.
      fetch(3, 32'h7777_7777); issue(2, 32'h7777_7777, 0, 0, 0, 0, 0, 0, 0);
      // Halt (with a simultaneous resume) at 0x20.
      fetch(1, 32'h8888_8888); issue(0, 32'h8888_8888, 1, 2'd1, 0, 32'h20, 32'h0, 0, 0);
      fetch(1, 32'h0010_0073); issue(0, 32'h0010_0073, 0, 0, 0, 0, 0, 1, 1);
      halted_wait(10);
      // PC wrap-around from the top of the address space.
      fetch(1, 32'h9999_9999); issue(0, 32'h9999_9999, 1, 2'd1, 0, 32'hFFFF_FFFC, 0, 0, 0);
      fetch(1, 32'hAAAA_AAAA); issue(0, 32'hAAAA_AAAA, 0, 0, 0, 0, 0, 0, 0);
      check("wrap_pc", pc, 0);

      for (int k = 0; k < 40; k++) begin
         d = $urandom;
         h = ($urandom_range(0, 7) == 0);
         fetch($urandom_range(1, 3), d);
         issue($urandom_range(0, 2), d, 1'($urandom), 2'($urandom), 1'($urandom), $urandom,
               $urandom, h, 1'($urandom));
         if (h) halted_wait($urandom_range(1, 4));
      end

      // Reset while a fetch is open; a late ack must not be captured.
      wait_req();
      rst = 1'b1;
      #1;
      check_reset_values();
      @(negedge clk);
      rst = 1'b0;
      imem_ack = 1'b1;
      imem_rdata = 32'hDEAD_BEEF;
      @(negedge clk);
      imem_ack = 1'b0;
      check("stale_inst", inst, 0);
      check("stale_valid", inst_valid, 0);
      check("refetch_req", imem_req, 1);
      check("refetch_addr", imem_addr, 0);
      m_pc = 32'h0;
      m_instret = 32'h0;
      fetch(1, 32'hBBBB_BBBB); issue(0, 32'hBBBB_BBBB, 0, 0, 0, 0, 0, 0, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Fetch-side controller for the single-cycle RISC-V core.
- Owns the program counter and runs the instruction-memory request/acknowledge handshake.
- Presents each fetched instruction to decode with a valid/ready handshake.
- Picks the next PC from the resolved control-flow outcome and drives the select lines of the core's PC-select multiplexer.
- Sits between instruction memory and decode, and adds halt/resume and a retired-instruction counter.

## Interface
- N, 32, PC and address width
- RESET_PC, 0, PC value loaded on reset
- TRAP_VEC, 32'h0000_0100, PC loaded on a trap redirect
---
- clk  in  1  single clock; all state changes on rising edge
- rst  in  1  asynchronous, active-high reset
- imem_req  out  1  fetch request to instruction memory
- imem_addr  out  N  fetch address; equals pc
- imem_ack  in  1  fetch complete; imem_rdata valid this cycle
- imem_rdata  in  32  fetched instruction word
- inst_valid  out  1  inst/inst_pc valid toward decode
- inst_ready  in  1  decode accepts the instruction this cycle
- inst  out  32  captured instruction
- inst_pc  out  N  address of inst
- redirect_valid  in  1  accepted instruction changes control flow
- redirect_kind  in  2  00 branch, 01 jal, 10 jalr, 11 trap
- branch_taken  in  1  branch condition result; used only for kind 00
- target_branch  in  N  pc+imm target, used for branch and jal
- target_jalr  in  N  rs1+imm target
- halt  in  1  accepted instruction is ecall/ebreak
- resume  in  1  leave HALTED
- pc  out  N  current program counter
- pc_sel1  out  1  PC-mux select bit 0
- pc_sel2  out  2  PC-mux select bits 2:1
- instret  out  32  retired-instruction count

## Operation
States: IDLE, FETCH, ISSUE, HALTED.
- IDLE: entered on reset; moves to FETCH on the first clock edge after rst falls.
- FETCH:
  - imem_req=1 and imem_addr=pc; both held stable until imem_ack.
  - On ack, capture imem_rdata into inst and pc into inst_pc, then go to ISSUE.
  - imem_ack with imem_req=0 is ignored.
- ISSUE:
  - inst_valid=1; inst and inst_pc stay stable until inst_ready.
  - On inst_valid and inst_ready ("accept"), instret increments and the next PC is loaded.
  - Priority for the next PC; {pc_sel2,pc_sel1} is driven combinationally during the accept cycle:
    - redirect_valid and kind 11: pc <= TRAP_VEC, select 001.
    - redirect_valid and kind 10: pc <= target_jalr with bit 0 cleared, select 110.
    - redirect_valid and (kind 01, or kind 00 with branch_taken=1): pc <= target_branch, select 100.
    - otherwise: pc <= inst_pc+4, select 000.
  - redirect_*, branch_taken and halt are sampled only on the accept cycle.
  - After accept: go to HALTED if halt=1, else to FETCH.
- HALTED: no requests; inst_valid=0. resume=1 moves to FETCH using the pc already loaded.
- {pc_sel2,pc_sel1}=000 whenever no accept occurs.
- Arithmetic: PC+4 is modulo 2^N, so wrap-around from 2^N-4 gives 0. instret wraps from 2^32-1 to 0.

## Timing
- Reset (async, immediate): state=IDLE, pc=RESET_PC, imem_addr=RESET_PC, imem_req=0, inst_valid=0, inst=0, inst_pc=0, instret=0, pc_sel1=0, pc_sel2=0.
- rst asserted mid-fetch or mid-issue: imem_req and inst_valid drop in the same cycle. A late imem_ack after release is ignored unless a new request is open.
- Fetch latency is one or more cycles; imem_ack may arrive in the first cycle imem_req is high.
- inst_valid rises the cycle after the ack edge. Best-case throughput is one instruction per 2 cycles (FETCH, ISSUE).
- Redirect and halt on the same accept: the PC redirect is applied and the state becomes HALTED.
- resume while not HALTED: no effect.
- halt and resume in the same accept cycle: HALTED is entered; resume is not honoured until the next cycle.

## Test plan
- Reset release, imem_ack one cycle after req, inst_ready tied 1: addresses 0x0, 0x4, 0x8 fetched; instret=3 after the third accept; selects 000.
- Taken branch at inst_pc 0x10 with target_branch 0x40: select 100 on the accept cycle; next imem_addr=0x40. Same case with branch_taken=0: next address 0x14.
- jalr with target_jalr 0x123: next pc 0x122, select 110. Trap: next pc 0x100, select 001.
- 3-cycle ack latency plus decode stalling inst_ready 2 cycles: imem_addr, inst and inst_pc stay stable throughout; exactly one instret increment.
- halt at 0x20: HALTED, no imem_req for 10 cycles; resume gives imem_addr=0x24. Also check pc 0xFFFF_FFFC advances to 0x0.
- Assert rst while imem_req=1, then ack after release: all outputs at reset values; stale ack ignored; first fetch from RESET_PC.
